// File: rtl/lc3_writeback.sv
// LC3 writeback stage: 8x16 register file, N/Z/P status register,
// result select and combinational dual read ports.
module lc3_writeback #(
   parameter bit         BYPASS    = 1'b0,
   parameter logic [2:0] RESET_PSR = 3'b000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable_writeback,
   input  logic [1:0]  W_Control,
   input  logic [15:0] aluout,
   input  logic [15:0] pcout,
   input  logic [15:0] memout,
   input  logic [2:0]  dr,
   input  logic [2:0]  sr1,
   input  logic [2:0]  sr2,
   output logic [15:0] VSR1,
   output logic [15:0] VSR2,
   output logic [2:0]  psr
);

   localparam int unsigned DW   = 16;
   localparam int unsigned PW   = 3;
   localparam int unsigned NREG = 8;

   localparam logic [1:0] SEL_ALU  = 2'd0;
   localparam logic [1:0] SEL_PC   = 2'd1;
   localparam logic [1:0] SEL_MEM  = 2'd2;
   localparam logic [1:0] SEL_NONE = 2'd3;

   logic [DW-1:0] regs_q [NREG];
   logic [PW-1:0] psr_q;
   logic [PW-1:0] psr_d;
   logic [DW-1:0] dr_in_c;
   logic          write_en_c;

   // Result select; the "no write" code still routes aluout.
   always_comb begin
      dr_in_c = aluout;
      unique case (W_Control)
         SEL_ALU:  dr_in_c = aluout;
         SEL_PC:   dr_in_c = pcout;
         SEL_MEM:  dr_in_c = memout;
         default:  dr_in_c = aluout;
      endcase
   end

   assign write_en_c = enable_writeback & (W_Control != SEL_NONE);

   // Status flags derived from the value being retired; exactly one bit set.
   always_comb begin
      psr_d = psr_q;
      if (write_en_c) begin
         psr_d[2] = dr_in_c[DW-1];
         psr_d[1] = (dr_in_c == '0);
         psr_d[0] = ~dr_in_c[DW-1] & (dr_in_c != '0);
      end
   end

   // Register file and status register; reset clears everything immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs_q[i] <= '0;
         end
         psr_q <= RESET_PSR;
      end else begin
         if (write_en_c) begin
            regs_q[dr] <= dr_in_c;
         end
         psr_q <= psr_d;
      end
   end

   // Combinational read ports with optional same-cycle forwarding of the write.
   always_comb begin
      VSR1 = regs_q[sr1];
      VSR2 = regs_q[sr2];
      if (BYPASS && write_en_c) begin
         if (sr1 == dr) VSR1 = dr_in_c;
         if (sr2 == dr) VSR2 = dr_in_c;
      end
   end

   assign psr = psr_q;

endmodule
